// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, 3-point majority vote per bit,
// optional even/odd parity, single stop bit, registered 1-cycle result pulses.
//
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low (this cycle is edge 0 of start)
//   START  | qualifying start bit; a resolved 1 is treated as a glitch
//   DATA   | sampling WIDTH data bits, LSB first
//   PARITY | sampling parity bit, mismatch recorded
//   STOP   | sampling stop bit; leaves at resolution, not at bit end
module uart_rx #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [WIDTH-1:0] P_DATA,
    output logic             DATA_VALID,
    output logic             PAR_ERR,
    output logic             STP_ERR
);

    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [EW-1:0] EDGE_S0   = EW'(OVERSAMPLE / 2 - 1);
    localparam logic [EW-1:0] EDGE_S1   = EW'(OVERSAMPLE / 2);
    localparam logic [EW-1:0] EDGE_RES  = EW'(OVERSAMPLE / 2 + 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic             rx_meta_q, rx_s_q;
    state_t           state_q, state_d;
    logic [EW-1:0]    edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [1:0]       samp_q, samp_d;
    logic             par_en_q, par_en_d;
    logic             par_typ_q, par_typ_d;
    logic             par_bad_q, par_bad_d;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             data_valid_q, data_valid_d;
    logic             par_err_q, par_err_d;
    logic             stp_err_q, stp_err_d;

    logic resolve, bit_val, par_exp;

    assign resolve = (edge_cnt_q == EDGE_RES);
    assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign par_exp = par_typ_q ? ~^shift_q : ^shift_q;

    // Bring the asynchronous serial line into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX_IN;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state, counters, sampling and result pulses.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q + EW'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        samp_d       = samp_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_bad_d    = par_bad_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (edge_cnt_q == EDGE_S0) samp_d[0] = rx_s_q;
        if (edge_cnt_q == EDGE_S1) samp_d[1] = rx_s_q;

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                if (!rx_s_q) begin
                    // The detecting cycle already counts as edge 0 of the start bit.
                    state_d    = START;
                    edge_cnt_d = EW'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_bad_d  = 1'b0;
                end
            end
            START: begin
                if (resolve && bit_val) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                end else if (edge_cnt_q == EDGE_LAST) begin
                    state_d    = DATA;
                    edge_cnt_d = '0;
                end
            end
            DATA: begin
                if (resolve) shift_d = {bit_val, shift_q[WIDTH-1:1]};
                if (edge_cnt_q == EDGE_LAST) begin
                    edge_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (resolve && (bit_val != par_exp)) par_bad_d = 1'b1;
                if (edge_cnt_q == EDGE_LAST) begin
                    state_d    = STOP;
                    edge_cnt_d = '0;
                end
            end
            STOP: begin
                // Leaving at mid-bit gives slack for back-to-back frames and clock skew.
                if (resolve) begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    if (bit_val && !par_bad_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                    par_err_d = par_bad_q;
                    stp_err_d = ~bit_val;
                end
            end
            default: begin
                state_d    = IDLE;
                edge_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            samp_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            samp_q       <= samp_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;

endmodule
